ad7985_adc_emulator: RTL
========================

# ad7985_adc_emulator

- Synthesizable responder model of an AD7985 16-bit ADC serial port (3-wire mode, no busy indicator).
- Receives CNV, SCK and TURBIO from the FPGA-side ADC controller and returns conversion results on SDO.
- Used for on-chip loopback and bench verification of the controller without the physical converter.
- Sample words come from an internal ramp generator or a host-loaded fixed value.

## Interface
Parameters:
- CONV_CYCLES, 35: conversion duration in clk cycles, normal mode.
- TURBO_CONV_CYCLES, 25: conversion duration in clk cycles when turbio=1.
- RAMP_STEP, 1: ramp increment per conversion, 16-bit.

Ports:
- clk  in  1  system clock; every input is synchronous to clk.
- reset  in  1  asynchronous, active-high reset.
- cnv  in  1  convert start from the controller.
- sck  in  1  serial clock from the controller; high and low phases are each ≥1 clk.
- turbio  in  1  selects turbo conversion time; sampled at the start of a conversion.
- sdo  out  1  serial data, MSB first; 0 whenever sdo_oe=0.
- sdo_oe  out  1  SDO drive enable; the top level builds the tristate from it.
- pattern_sel  in  1  0: ramp word, 1: fixed word.
- data_in  in  16  fixed-word value.
- data_load  in  1  one-cycle strobe that writes data_in into the fixed-word register.
- clear_flags  in  1  clears overrun and early_read.
- conv_busy  out  1  high while a conversion is in progress.
- sample_count  out  16  number of conversions started; wraps.
- overrun  out  1  sticky: cnv rose during a conversion.
- early_read  out  1  sticky: an sck falling edge arrived while no data was valid.

## Operation
- Input stage: cnv and sck are each registered twice (q1, q2).
  - Rising edge = q1 & ~q2; falling edge = ~q1 & q2.
  - T0 = the cycle in which an edge is detected.
- FSM states:
  - IDLE: sdo_oe=0.
    - cnv rise → CONV.
  - CONV: conv_busy=1; down-counter loaded with the turbio-selected length.
    - Counter expiry with cnv_q1=0 → READ.
    - Counter expiry with cnv_q1=1 → WAIT_LOW.
  - WAIT_LOW: sdo_oe=0.
    - cnv fall → READ.
    - cnv rise is impossible while cnv is high.
  - READ: sdo_oe=1, sdo = shift-register MSB.
    - Each sck fall shifts the register left by 1 and increments the bit counter.
    - The 16th fall → IDLE.
    - cnv rise → CONV (abort readout, start a new conversion).
- At a conversion start (T0):
  - Shift register ← ramp mode: ramp counter; fixed mode: fixed register, using its value before any data_load in the same cycle.
  - Ramp counter += RAMP_STEP, mod 2^16.
  - sample_count += 1, wraps 0xFFFF→0x0000.
- cnv rise while in CONV: ignored (no restart, no count); overrun←1.
- sck fall in IDLE, CONV or WAIT_LOW: no shift; early_read←1.
- clear_flags in the same cycle as a flag-setting event: set wins.
- The last bit holds on sdo until sdo_oe drops.

## Timing
- Reset values:
  - FSM IDLE; sdo=0, sdo_oe=0, conv_busy=0.
  - sample_count=0, ramp counter=0, fixed register=0.
  - overrun=0, early_read=0.
- cnv rise detect at T0 → conv_busy=1 from T0+1 for exactly N cycles (N=CONV_CYCLES or TURBO_CONV_CYCLES).
- Expiry with cnv low → sdo_oe=1 and sdo=bit15 at T0+N+1.
- WAIT_LOW: cnv fall detected at T0 → sdo_oe=1, sdo=bit15 at T0+1.
- sck fall k (k=1..15) detected at T0 → sdo = bit(15-k) at T0+1.
- sck fall 16 detected at T0 → sdo_oe=0, sdo=0 at T0+1.
- cnv rise during READ at T0 → sdo_oe=0 and conv_busy=1 at T0+1.
- Reset asserted mid-conversion or mid-readout → all outputs at reset values immediately (asynchronous).
- Pin-to-detect latency is 2 clk; the controller accounts for it.

## Test plan
- Reset, pattern_sel=0, turbio=0, one cnv pulse then 16 sck falls → bits read 0x0000, conv_busy high for exactly 35 cycles, sample_count=1, second frame reads 0x0001.
- data_load 0xE789, pattern_sel=1, turbio=1 → conv_busy 25 cycles; serial bits 1110 0111 1000 1001; sdo_oe low 1 cycle after the 16th fall.
- cnv held high past conversion end → sdo_oe stays 0 until cnv falls, then bit15 valid 1 cycle after detect.
- Second cnv rise mid-conversion → conversion length unchanged, sample_count +1 only, overrun=1; clear_flags → 0.
- sck falls before conversion end → early_read=1, no shift; a subsequent normal readout returns the correct word.
- Ramp preset near the wrap point (RAMP_STEP=0x4000, 5 frames) → 0x0000, 0x4000, 0x8000, 0xC000, 0x0000; cnv rise after 8 bits aborts the frame; async reset mid-readout clears sdo_oe at once.

Source files
------------

// File: rtl/ad7985_adc_emulator_if.sv
// Serial-port bundle between an AD7985 controller (master) and the ADC or
// its emulator (slave), 3-wire mode without busy indicator.
interface ad7985_adc_emulator_if;
    // Handshake: a cnv rising edge starts a conversion; the slave's word is
    // valid on sdo only while sdo_oe=1, and each sck falling edge accepted in
    // that window consumes the current bit and presents the next one. A frame
    // is 16 accepted falls; sdo_oe drops after the last one.
    logic cnv;
    logic sck;
    logic turbio;
    logic sdo;
    logic sdo_oe;

    modport master (
        output cnv,
        output sck,
        output turbio,
        input  sdo,
        input  sdo_oe
    );

    modport slave (
        input  cnv,
        input  sck,
        input  turbio,
        output sdo,
        output sdo_oe
    );
endinterface

// File: rtl/ad7985_adc_emulator.sv
// AD7985 serial-port responder: runs a timed conversion on each cnv rise and
// shifts a ramp or host-loaded word out MSB first on sck falling edges.
module ad7985_adc_emulator #(
    parameter int          CONV_CYCLES       = 35,
    parameter int          TURBO_CONV_CYCLES = 25,
    parameter logic [15:0] RAMP_STEP         = 16'd1
) (
    input  logic                         clk,
    input  logic                         reset,
    ad7985_adc_emulator_if.slave         adc,
    input  logic                         pattern_sel,
    input  logic [15:0]                  data_in,
    input  logic                         data_load,
    input  logic                         clear_flags,
    output logic                         conv_busy,
    output logic [15:0]                  sample_count,
    output logic                         overrun,
    output logic                         early_read,
    output logic [1:0]                   fsm_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONV     = 2'd1,
        WAIT_LOW = 2'd2,
        READ     = 2'd3
    } state_t;

    localparam logic [15:0] CONV_LOAD  = 16'(CONV_CYCLES - 1);
    localparam logic [15:0] TURBO_LOAD = 16'(TURBO_CONV_CYCLES - 1);

    state_t      state;
    state_t      state_nx;

    logic        cnv_q1;
    logic        cnv_q2;
    logic        sck_q1;
    logic        sck_q2;
    logic        cnv_rise;
    logic        cnv_fall;
    logic        sck_fall;

    logic [15:0] conv_cnt;
    logic [15:0] shreg;
    logic [3:0]  bit_cnt;
    logic [15:0] ramp_cnt;
    logic [15:0] fixed_reg;

    logic        start_conv;
    logic        shift;
    logic        ovr_set;
    logic        early_set;

    // Two-stage input registers; edges are judged between the two stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnv_q1 <= 1'b0;
            cnv_q2 <= 1'b0;
            sck_q1 <= 1'b0;
            sck_q2 <= 1'b0;
        end else begin
            cnv_q1 <= adc.cnv;
            cnv_q2 <= cnv_q1;
            sck_q1 <= adc.sck;
            sck_q2 <= sck_q1;
        end
    end

    assign cnv_rise = cnv_q1 & ~cnv_q2;
    assign cnv_fall = ~cnv_q1 & cnv_q2;
    assign sck_fall = ~sck_q1 & sck_q2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        start_conv = 1'b0;
        shift      = 1'b0;
        ovr_set    = 1'b0;
        early_set  = 1'b0;
        case (state)
            IDLE: begin
                early_set = sck_fall;
                if (cnv_rise) begin
                    state_nx   = CONV;
                    start_conv = 1'b1;
                end
            end
            CONV: begin
                ovr_set   = cnv_rise;
                early_set = sck_fall;
                if (conv_cnt == 16'd0) begin
                    state_nx = cnv_q1 ? WAIT_LOW : READ;
                end
            end
            WAIT_LOW: begin
                early_set = sck_fall;
                if (cnv_fall) begin
                    state_nx = READ;
                end
            end
            READ: begin
                // A new conversion request abandons the frame in progress.
                if (cnv_rise) begin
                    state_nx   = CONV;
                    start_conv = 1'b1;
                end else if (sck_fall) begin
                    shift = 1'b1;
                    if (bit_cnt == 4'd15) begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conv_cnt <= 16'd0;
        end else if (start_conv) begin
            conv_cnt <= adc.turbio ? TURBO_LOAD : CONV_LOAD;
        end else if (state == CONV && conv_cnt != 16'd0) begin
            conv_cnt <= conv_cnt - 16'd1;
        end
    end

    // The sample word is captured from fixed_reg's current value, so a
    // data_load in the same cycle only affects later conversions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg   <= 16'd0;
            bit_cnt <= 4'd0;
        end else if (start_conv) begin
            shreg   <= pattern_sel ? fixed_reg : ramp_cnt;
            bit_cnt <= 4'd0;
        end else if (shift) begin
            shreg   <= {shreg[14:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ramp_cnt     <= 16'd0;
            sample_count <= 16'd0;
        end else if (start_conv) begin
            ramp_cnt     <= ramp_cnt + RAMP_STEP;
            sample_count <= sample_count + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fixed_reg <= 16'd0;
        end else if (data_load) begin
            fixed_reg <= data_in;
        end
    end

    // Sticky flags: a set event in the same cycle as clear_flags wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun    <= 1'b0;
            early_read <= 1'b0;
        end else begin
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
            if (early_set) begin
                early_read <= 1'b1;
            end else if (clear_flags) begin
                early_read <= 1'b0;
            end
        end
    end

    assign conv_busy  = (state == CONV);
    assign adc.sdo_oe = (state == READ);
    assign adc.sdo    = (state == READ) & shreg[15];
    assign fsm_state  = state;

endmodule
